spu_fetch_buffer: RTL and testbench

Instruction-supply end of the SPU dual-issue front end. It fetches 128-bit quadwords (four instructions each) from local-store instruction memory and buffers them. Each cycle it presents the next two sequential instructions to decode as slot 0 and slot 1. Decode returns how many it issued: 2 for a dual issue, 1 on a structural hazard, 0 on a stall. A redirect input flushes the buffer and restarts fetch at a new PC.

---
 rtl/spu_fetch_buffer.sv | 176 +++++++++++++++++
 tb/tb_spu_fetch_buffer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/spu_fetch_buffer.sv
// spu_fetch_buffer: quadword instruction fetch into a DEPTH-word circular buffer feeding two decode slots.
// Optional FETCH_PERF_EN adds perf_empty, a saturating count of cycles with slot 0 empty.
module spu_fetch_buffer #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      RFWIDTH  = 128,
    parameter int unsigned      DEPTH    = 8,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [WIDTH-1:0]   imem_adr,
    input  logic               imem_ack,
    input  logic [RFWIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0]   instr0,
    output logic [WIDTH-1:0]   instr1,
    output logic               valid0,
    output logic               valid1,
    output logic [WIDTH-1:0]   pc0,
`ifdef FETCH_PERF_EN
    output logic [WIDTH-1:0]   perf_empty,
`endif
    input  logic [1:0]         issue,
    input  logic               redirect,
    input  logic [WIDTH-1:0]   redirect_pc
);

    localparam int unsigned PTRW = $clog2(DEPTH);
    localparam int unsigned CW   = PTRW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DISCARD
    } state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic [WIDTH-1:0]  adr_q, adr_d;
    logic [WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
    logic [1:0]        skip_q, skip_d;
    logic [WIDTH-1:0]  pc0_q, pc0_d;
    logic [PTRW-1:0]   rd_q, rd_d;
    logic [PTRW-1:0]   wr_q, wr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [WIDTH-1:0]  buf_q [DEPTH];
    logic [WIDTH-1:0]  buf_d [DEPTH];

    logic [1:0]        issue_eff;
    logic [CW-1:0]     consumed;
    logic [CW-1:0]     count_after;
    logic [2:0]        fill;
    logic [PTRW-1:0]   rd1;

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        adr_d      = adr_q;
        fetch_pc_d = fetch_pc_q;
        skip_d     = skip_q;
        pc0_d      = pc0_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        count_d    = count_q;
        buf_d      = buf_q;

        issue_eff   = (issue == 2'd3) ? 2'd2 : issue;
        consumed    = (count_q < CW'(issue_eff)) ? count_q : CW'(issue_eff);
        count_after = count_q - consumed;
        fill        = 3'd4 - {1'b0, skip_q};

        if (redirect) begin
            // Redirect wins over issue and ack; an in-flight request must still be drained.
            count_d    = '0;
            rd_d       = '0;
            wr_d       = '0;
            pc0_d      = redirect_pc & ~WIDTH'(3);
            fetch_pc_d = redirect_pc & ~WIDTH'(15);
            skip_d     = redirect_pc[3:2];
            if (state_q == S_REQ || state_q == S_DISCARD) begin
                if (imem_ack) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                end else begin
                    state_d = S_DISCARD;
                end
            end
        end else begin
            rd_d    = rd_q + PTRW'(consumed);
            pc0_d   = pc0_q + (WIDTH'(consumed) << 2);
            count_d = count_after;
            unique case (state_q)
                S_IDLE: begin
                    if (count_after <= CW'(DEPTH - 4)) begin
                        req_d   = 1'b1;
                        adr_d   = fetch_pc_q;
                        state_d = S_REQ;
                    end
                end
                S_REQ: begin
                    if (imem_ack) begin
                        for (int unsigned j = 0; j < 4; j++) begin
                            if (j >= 32'(skip_q)) begin
                                buf_d[wr_q + PTRW'(j - 32'(skip_q))] =
                                    imem_rdata[(3 - j) * WIDTH +: WIDTH];
                            end
                        end
                        wr_d       = wr_q + PTRW'(fill);
                        count_d    = count_after + CW'(fill);
                        skip_d     = 2'd0;
                        fetch_pc_d = fetch_pc_q + WIDTH'(16);
                        req_d      = 1'b0;
                        state_d    = S_IDLE;
                    end
                end
                S_DISCARD: begin
                    if (imem_ack) begin
                        req_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            adr_q      <= '0;
            fetch_pc_q <= RESET_PC & ~WIDTH'(15);
            skip_q     <= RESET_PC[3:2];
            pc0_q      <= RESET_PC & ~WIDTH'(3);
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
            buf_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            adr_q      <= adr_d;
            fetch_pc_q <= fetch_pc_d;
            skip_q     <= skip_d;
            pc0_q      <= pc0_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            count_q    <= count_d;
            buf_q      <= buf_d;
        end
    end

    assign rd1      = rd_q + PTRW'(1);
    assign valid0   = (count_q != '0);
    assign valid1   = (count_q >= CW'(2));
    assign instr0   = valid0 ? buf_q[rd_q] : '0;
    assign instr1   = valid1 ? buf_q[rd1] : '0;
    assign pc0      = pc0_q;
    assign imem_req = req_q;
    assign imem_adr = adr_q;

`ifdef FETCH_PERF_EN
    logic [WIDTH-1:0] perf_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_q <= '0;
        end else if (!valid0 && perf_q != '1) begin
            perf_q <= perf_q + WIDTH'(1);
        end
    end

    assign perf_empty = perf_q;
`endif

endmodule

// File: tb/tb_spu_fetch_buffer.sv
// Bench for spu_fetch_buffer: directed scenarios then random traffic, checked against a queue-based program-order model.
module tb_spu_fetch_buffer;

    localparam logic [31:0] RPC = 32'h0;

    logic         clk = 1'b0;
    logic         reset;
    logic         imem_req;
    logic [31:0]  imem_adr;
    logic         imem_ack;
    logic [127:0] imem_rdata;
    logic [31:0]  instr0, instr1, pc0;
    logic         valid0, valid1;
    logic [1:0]   issue;
    logic         redirect;
    logic [31:0]  redirect_pc;

    int checks = 0;
    int errors = 0;

    // Model: queue of buffered instruction addresses in program order plus fetch bookkeeping.
    logic [31:0] mq[$];
    logic [31:0] m_pc0, m_fetch, m_adr;
    logic [1:0]  m_skip;
    bit          m_out, m_stale;

    always #5 clk = ~clk;

    spu_fetch_buffer #(
        .WIDTH(32), .RFWIDTH(128), .DEPTH(8), .RESET_PC(RPC)
    ) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_adr(imem_adr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr0(instr0), .instr1(instr1),
        .valid0(valid0), .valid1(valid1), .pc0(pc0), .issue(issue),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc0   = RPC & ~32'd3;
        m_fetch = RPC & ~32'd15;
        m_skip  = RPC[3:2];
        m_adr   = 32'd0;
        m_out   = 1'b0;
        m_stale = 1'b0;
    endtask

    task automatic check_outputs();
        logic [31:0] e0, e1;
        e0 = (mq.size() >= 1) ? mem_word(mq[0]) : 32'd0;
        e1 = (mq.size() >= 2) ? mem_word(mq[1]) : 32'd0;
        chk("valid0", 32'(valid0), 32'(mq.size() >= 1));
        chk("valid1", 32'(valid1), 32'(mq.size() >= 2));
        chk("instr0", instr0, e0);
        chk("instr1", instr1, e1);
        chk("pc0", pc0, m_pc0);
        chk("imem_req", 32'(imem_req), 32'(m_out));
        chk("imem_adr", imem_adr, m_adr);
    endtask

    // One cycle: check outputs, drive inputs, advance the model across the next posedge.
    task automatic step(input bit rst_n, input int iss, input bit ack, input bit redir,
                        input logic [31:0] rpc);
        int eff, n;
        check_outputs();
        reset       = rst_n;
        issue       = 2'(iss);
        imem_ack    = ack;
        redirect    = redir;
        redirect_pc = rpc;
        imem_rdata  = {mem_word(imem_adr), mem_word(imem_adr + 32'd4),
                       mem_word(imem_adr + 32'd8), mem_word(imem_adr + 32'd12)};
        if (!rst_n) begin
            model_reset();
        end else if (redir) begin
            mq.delete();
            m_pc0   = rpc & ~32'd3;
            m_fetch = rpc & ~32'd15;
            m_skip  = rpc[3:2];
            if (m_out) begin
                if (ack) m_out = 1'b0;
                else     m_stale = 1'b1;
            end
        end else begin
            eff = (iss > 2) ? 2 : iss;
            n   = (eff < mq.size()) ? eff : mq.size();
            repeat (n) void'(mq.pop_front());
            m_pc0 = m_pc0 + 32'(4 * n);
            if (m_out) begin
                if (ack) begin
                    if (!m_stale) begin
                        for (int j = int'(m_skip); j < 4; j++) mq.push_back(m_adr + 32'(4 * j));
                        m_skip  = 2'd0;
                        m_fetch = m_fetch + 32'd16;
                    end
                    m_out = 1'b0;
                end
            end else if (mq.size() <= 4) begin
                m_out   = 1'b1;
                m_stale = 1'b0;
                m_adr   = m_fetch;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_req();
        for (int k = 0; k < 20 && !m_out; k++) step(1, 2, 0, 0, 32'd0);
        chk("req_reached", 32'(imem_req), 32'd1);
    endtask

    initial begin
        reset = 1'b0; issue = 2'd0; imem_ack = 1'b0; redirect = 1'b0;
        redirect_pc = 32'd0; imem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();

        // Cold start: reset state, then first request and its data.
        step(0, 0, 0, 0, 32'd0);
        step(1, 0, 0, 0, 32'd0);
        step(1, 0, 1, 0, 32'd0);

        // Alternating dual/single issue with memory always ready.
        for (int i = 0; i < 12; i++) step(1, (i % 2 == 0) ? 2 : 1, 1, 0, 32'd0);

        // Hold issue to fill the buffer, then drain two and confirm no premature request.
        for (int i = 0; i < 12; i++) step(1, 0, 1, 0, 32'd0);
        step(1, 2, 1, 0, 32'd0);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 32'd0);

        // Redirect mid-request; stale ack two cycles later must be dropped.
        wait_req();
        step(1, 0, 0, 1, 32'h0000_0104);
        step(1, 0, 0, 0, 32'd0);
        step(1, 0, 1, 0, 32'd0);
        step(1, 0, 0, 0, 32'd0);
        step(1, 0, 1, 0, 32'd0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 32'd0);

        // Redirect coinciding with ack.
        wait_req();
        step(1, 1, 1, 1, 32'h0000_0238);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 32'd0);

        // Reset asserted while a request is outstanding, with a late ack afterwards.
        wait_req();
        step(0, 0, 0, 0, 32'd0);
        step(1, 0, 1, 0, 32'd0);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 32'd0);

        // Random traffic including wrap-around redirect targets and occasional resets.
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 99) != 0), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) < 5), ($urandom_range(0, 29) == 0), $urandom());
        end
        check_outputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
